// File: rtl/rtc_hms_counter_if.sv
// Control and time-of-day bundle between the timekeeping block and its user.
// The user drives enable/load/alarm settings; the counter returns time and pulses.
interface rtc_hms_counter_if;
    logic       en;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hr;
    logic       alarm_en;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hr;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       sec_tick;
    logic       min_tick;
    logic       hr_tick;
    logic       day_tick;
    logic       alarm_hit;

    modport master (
        output en, load, load_sec, load_min, load_hr,
        output alarm_en, alarm_min, alarm_hr,
        input  sec, min, hr,
        input  sec_tick, min_tick, hr_tick, day_tick, alarm_hit
    );

    modport slave (
        input  en, load, load_sec, load_min, load_hr,
        input  alarm_en, alarm_min, alarm_hr,
        output sec, min, hr,
        output sec_tick, min_tick, hr_tick, day_tick, alarm_hit
    );
endinterface

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter: prescaled 1 s event drives a sec/min/hr cascade with
// load, rollover pulses and a minute-resolution alarm, all registered on clk.
module rtc_hms_counter #(
    parameter int unsigned CLK_PER_SEC   = 1,
    parameter int unsigned HOURS_PER_DAY = 24
) (
    input  logic              clk,
    input  logic              rst,
    rtc_hms_counter_if.slave  bus
);

    localparam int unsigned    PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [5:0]     SM_LAST    = 6'd59;
    localparam logic [4:0]     HR_LAST    = 5'(HOURS_PER_DAY - 1);
    localparam logic [5:0]     HR_LIMIT   = 6'(HOURS_PER_DAY);

    logic [PW-1:0] presc;
    logic [5:0]    sec_q;
    logic [5:0]    min_q;
    logic [4:0]    hr_q;
    logic          sec_tick_q;
    logic          min_tick_q;
    logic          hr_tick_q;
    logic          day_tick_q;
    logic          alarm_hit_q;

    logic          second_evt;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hr_wrap;
    logic [5:0]    sec_inc;
    logic [5:0]    min_inc;
    logic [4:0]    hr_inc;
    logic [5:0]    ld_sec;
    logic [5:0]    ld_min;
    logic [4:0]    ld_hr;
    logic          alarm_match;

    // Cascade: every stage computes its post-event value in the same cycle,
    // so the whole carry chain settles on one edge.
    always_comb begin
        second_evt = bus.en && (presc == PRESC_LAST);
        sec_wrap   = (sec_q == SM_LAST);
        min_wrap   = sec_wrap && (min_q == SM_LAST);
        hr_wrap    = min_wrap && (hr_q == HR_LAST);

        sec_inc = sec_wrap ? '0 : sec_q + 6'd1;
        min_inc = min_q;
        if (sec_wrap) begin
            min_inc = (min_q == SM_LAST) ? '0 : min_q + 6'd1;
        end
        hr_inc = hr_q;
        if (min_wrap) begin
            hr_inc = (hr_q == HR_LAST) ? '0 : hr_q + 5'd1;
        end

        // Counters never leave their legal range, so out-of-range alarm
        // settings simply never compare equal.
        alarm_match = bus.alarm_en && (sec_inc == '0) &&
                      (min_inc == bus.alarm_min) && (hr_inc == bus.alarm_hr);
    end

    always_comb begin
        ld_sec = (bus.load_sec > SM_LAST) ? SM_LAST : bus.load_sec;
        ld_min = (bus.load_min > SM_LAST) ? SM_LAST : bus.load_min;
        ld_hr  = ({1'b0, bus.load_hr} >= HR_LIMIT) ? HR_LAST : bus.load_hr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hr_tick_q   <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hr_tick_q   <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            if (bus.load) begin
                // A coincident second event is dropped along with its pulses.
                presc <= '0;
                sec_q <= ld_sec;
                min_q <= ld_min;
                hr_q  <= ld_hr;
            end else if (bus.en) begin
                if (second_evt) begin
                    presc       <= '0;
                    sec_q       <= sec_inc;
                    min_q       <= min_inc;
                    hr_q        <= hr_inc;
                    sec_tick_q  <= 1'b1;
                    min_tick_q  <= sec_wrap;
                    hr_tick_q   <= min_wrap;
                    day_tick_q  <= hr_wrap;
                    alarm_hit_q <= alarm_match;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hr        = hr_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hr_tick   = hr_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Bench for rtc_hms_counter: three configurations share one stimulus stream and
// are each compared every cycle against a seconds-of-day reference model.
module tb_rtc_hms_counter;

    localparam int N = 3;

    function automatic int unsigned cfg_cps(int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned cfg_hpd(int k);
        case (k)
            0:       return 24;
            1:       return 12;
            default: return 1;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_sec = '0;
    logic [5:0] load_min = '0;
    logic [4:0] load_hr = '0;
    logic       alarm_en = 1'b0;
    logic [5:0] alarm_min = '0;
    logic [4:0] alarm_hr = '0;

    logic [5:0] sec_o [N];
    logic [5:0] min_o [N];
    logic [4:0] hr_o  [N];
    logic       st_o  [N];
    logic       mt_o  [N];
    logic       ht_o  [N];
    logic       dt_o  [N];
    logic       ah_o  [N];

    rtc_hms_counter_if bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign bus[g].en        = en;
        assign bus[g].load      = load;
        assign bus[g].load_sec  = load_sec;
        assign bus[g].load_min  = load_min;
        assign bus[g].load_hr   = load_hr;
        assign bus[g].alarm_en  = alarm_en;
        assign bus[g].alarm_min = alarm_min;
        assign bus[g].alarm_hr  = alarm_hr;

        rtc_hms_counter #(
            .CLK_PER_SEC   (cfg_cps(g)),
            .HOURS_PER_DAY (cfg_hpd(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );

        assign sec_o[g] = bus[g].sec;
        assign min_o[g] = bus[g].min;
        assign hr_o[g]  = bus[g].hr;
        assign st_o[g]  = bus[g].sec_tick;
        assign mt_o[g]  = bus[g].min_tick;
        assign ht_o[g]  = bus[g].hr_tick;
        assign dt_o[g]  = bus[g].day_tick;
        assign ah_o[g]  = bus[g].alarm_hit;
    end

    always #5 clk = ~clk;

    typedef struct {
        int sec, min, hr, st, mt, ht, dt, ah;
    } exp_t;

    int   t [N];
    int   p [N];
    exp_t e [N];
    int   errors = 0;
    int   checks = 0;
    int   hits0  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: time held as seconds since midnight; fields derived by division.
    task automatic model_edge(input int k);
        int cps, hpd, day, s, m, h;
        cps = int'(cfg_cps(k));
        hpd = int'(cfg_hpd(k));
        day = hpd * 3600;
        e[k].st = 0; e[k].mt = 0; e[k].ht = 0; e[k].dt = 0; e[k].ah = 0;
        if (rst) begin
            t[k] = 0;
            p[k] = 0;
        end else if (load) begin
            s = (int'(load_sec) > 59) ? 59 : int'(load_sec);
            m = (int'(load_min) > 59) ? 59 : int'(load_min);
            h = (int'(load_hr) >= hpd) ? hpd - 1 : int'(load_hr);
            t[k] = h * 3600 + m * 60 + s;
            p[k] = 0;
        end else if (en) begin
            if (p[k] == cps - 1) begin
                p[k] = 0;
                t[k] = (t[k] + 1) % day;
                e[k].st = 1;
                e[k].mt = (t[k] % 60 == 0) ? 1 : 0;
                e[k].ht = (t[k] % 3600 == 0) ? 1 : 0;
                e[k].dt = (t[k] == 0) ? 1 : 0;
                e[k].ah = (alarm_en && int'(alarm_min) < 60 && int'(alarm_hr) < hpd &&
                           t[k] == int'(alarm_hr) * 3600 + int'(alarm_min) * 60) ? 1 : 0;
            end else begin
                p[k] = p[k] + 1;
            end
        end
        e[k].sec = t[k] % 60;
        e[k].min = (t[k] / 60) % 60;
        e[k].hr  = t[k] / 3600;
    endtask

    task automatic step();
        for (int k = 0; k < N; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("d%0d.sec", k), 32'(sec_o[k]), e[k].sec);
            check($sformatf("d%0d.min", k), 32'(min_o[k]), e[k].min);
            check($sformatf("d%0d.hr", k),  32'(hr_o[k]),  e[k].hr);
            check($sformatf("d%0d.sec_tick", k),  32'(st_o[k]), e[k].st);
            check($sformatf("d%0d.min_tick", k),  32'(mt_o[k]), e[k].mt);
            check($sformatf("d%0d.hr_tick", k),   32'(ht_o[k]), e[k].ht);
            check($sformatf("d%0d.day_tick", k),  32'(dt_o[k]), e[k].dt);
            check($sformatf("d%0d.alarm_hit", k), 32'(ah_o[k]), e[k].ah);
        end
        if (ah_o[0] === 1'b1) hits0++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hr  = 5'(h);
        load_min = 6'(m);
        load_sec = 6'(s);
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    function automatic int hms0();
        return int'(hr_o[0]) * 3600 + int'(min_o[0]) * 60 + int'(sec_o[0]);
    endfunction

    initial begin
        int r;

        // Reset, then free run: dut0 ticks every 4th cycle.
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        en  = 1'b1;
        steps(16);
        check("run16_time", 32'(hms0()), 4);

        // Minute and hour carry in the same cycle.
        do_load(0, 59, 58);
        steps(8);
        check("carry_to_01h", 32'(hms0()), 3600);

        // End of day wrap; saturated load maps to last second of day.
        do_load(23, 59, 59);
        steps(4);
        check("day_wrap", 32'(hms0()), 0);
        do_load(31, 63, 63);
        check("sat_load", 32'(hms0()), 23 * 3600 + 59 * 60 + 59);

        // Load coinciding with a prescaler wrap on dut0.
        for (int i = 0; i < 4 && p[0] != 3; i++) step();
        do_load(5, 10, 20);
        check("load_on_wrap", 32'(hms0()), 5 * 3600 + 10 * 60 + 20);
        steps(4);

        // Alarm: single pulse, disabled, and direct load onto alarm time.
        alarm_en  = 1'b1;
        alarm_hr  = 5'd7;
        alarm_min = 6'd30;
        hits0 = 0;
        do_load(7, 29, 59);
        steps(8);
        check("alarm_once", 32'(hits0), 1);
        alarm_en = 1'b0;
        hits0 = 0;
        do_load(7, 29, 59);
        steps(8);
        check("alarm_disabled", 32'(hits0), 0);
        alarm_en = 1'b1;
        hits0 = 0;
        do_load(7, 30, 0);
        steps(3);
        check("alarm_on_load", 32'(hits0), 0);

        // Freeze mid-second, then reset mid-count.
        steps(2);
        en = 1'b0;
        steps(10);
        en = 1'b1;
        steps(8);
        steps(2);
        rst = 1'b1;
        step();
        check("mid_rst", 32'(hms0()), 0);
        rst = 1'b0;
        steps(4);
        check("first_tick_after_rst", 32'(st_o[0]), 1);

        // Randomised traffic biased towards rollovers and alarm matches.
        for (int i = 0; i < 3000; i++) begin
            r    = int'($urandom_range(0, 99));
            rst  = (r == 0);
            load = (r >= 1 && r < 5);
            en   = ($urandom_range(0, 9) != 0);
            if (load) begin
                if ($urandom_range(0, 1) == 1) begin
                    load_sec = 6'($urandom_range(55, 63));
                    load_min = 6'($urandom_range(57, 63));
                end else begin
                    load_sec = 6'($urandom_range(0, 63));
                    load_min = 6'($urandom_range(0, 63));
                end
                load_hr = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 1) begin
                    alarm_hr  = load_hr;
                    alarm_min = load_min + 6'd1;
                end else begin
                    alarm_hr  = 5'($urandom_range(0, 31));
                    alarm_min = 6'($urandom_range(0, 63));
                end
                alarm_en = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        rst  = 1'b0;
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
